// File: rtl/spike_window_counter_if.sv
// Port bundle for the windowed spike-rate monitor: control, spike inputs,
// read port and status outputs. master drives the inputs, slave is the monitor.
interface spike_window_counter_if #(
  parameter int NUM_CH = 16,
  parameter int WIN_W  = 24,
  parameter int SEL_W  = 6
);
  logic              run;
  logic              clear;
  logic [WIN_W-1:0]  window_len;
  logic [NUM_CH-1:0] spike_in;
  logic [SEL_W-1:0]  rd_sel;
  logic [31:0]       rd_data;
  logic              window_done;
  logic [15:0]       window_idx;
  logic [NUM_CH-1:0] sat_flags;
  logic              busy;
  logic [1:0]        state_dbg;

  modport master (
    output run, clear, window_len, spike_in, rd_sel,
    input  rd_data, window_done, window_idx, sat_flags, busy, state_dbg
  );

  modport slave (
    input  run, clear, window_len, spike_in, rd_sel,
    output rd_data, window_done, window_idx, sat_flags, busy, state_dbg
  );
endinterface

// File: rtl/spike_window_counter.sv
// Windowed per-channel spike counter with snapshot-at-boundary, sticky
// saturation tracking and a registered 32-bit addressable read port.
module spike_window_counter #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 24,
  parameter int SEL_W  = 6
) (
  input logic                   clk,
  input logic                   reset,
  spike_window_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [CNT_W-1:0]  live [NUM_CH];
  logic [CNT_W-1:0]  snap [NUM_CH];
  logic [NUM_CH-1:0] win_sat;
  logic [NUM_CH-1:0] snap_sat;
  logic [NUM_CH-1:0] sat_flags;
  logic [WIN_W-1:0]  timer;
  logic [WIN_W-1:0]  len;
  logic [15:0]       window_idx;
  logic [31:0]       rd_data;
  logic              window_done;

  logic [CNT_W-1:0]  live_add [NUM_CH];
  logic [NUM_CH-1:0] add_sat;
  logic [WIN_W-1:0]  len_sample;
  logic              terminal;
  logic [31:0]       rd_word;

  // A spike on a counter already at full scale is dropped and flagged.
  always_comb begin
    add_sat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      add_sat[i]  = bus.spike_in[i] && (live[i] == CNT_MAX);
      live_add[i] = live[i] + CNT_W'(bus.spike_in[i] && !add_sat[i]);
    end
  end

  assign len_sample = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
  assign terminal   = (state != IDLE) && (timer == len - WIN_W'(1));

  // Read port: rd_sel presented in cycle N is answered on rd_data in cycle N+1;
  // there is no handshake, every cycle is a read.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        rd_word[CNT_W-1:0] = snap[i];
        rd_word[31]        = snap_sat[i];
      end
    end
    if (bus.rd_sel == '1) rd_word = {16'h0, window_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      for (int i = 0; i < NUM_CH; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
      win_sat     <= '0;
      snap_sat    <= '0;
      sat_flags   <= '0;
      timer       <= '0;
      len         <= '0;
      window_idx  <= '0;
      rd_data     <= '0;
      window_done <= 1'b0;
    end else begin
      rd_data     <= rd_word;
      window_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            len   <= len_sample;
            timer <= '0;
            state <= COUNT;
          end
        end
        COUNT, DRAIN: begin
          if (terminal && !bus.clear) begin
            // Terminal cycle's spikes land in the snapshot, so the next
            // window starts from zero with no dead cycle.
            for (int i = 0; i < NUM_CH; i++) begin
              snap[i] <= live_add[i];
              live[i] <= '0;
            end
            snap_sat    <= win_sat | add_sat;
            win_sat     <= '0;
            sat_flags   <= sat_flags | add_sat;
            timer       <= '0;
            window_idx  <= window_idx + 16'd1;
            window_done <= 1'b1;
            len         <= len_sample;
            state       <= bus.run ? COUNT : IDLE;
          end else begin
            for (int i = 0; i < NUM_CH; i++) live[i] <= live_add[i];
            win_sat   <= win_sat | add_sat;
            sat_flags <= sat_flags | add_sat;
            timer     <= timer + WIN_W'(1);
            state     <= bus.run ? COUNT : DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
      // clear overrides counting and suppresses any boundary on this edge.
      if (bus.clear) begin
        for (int i = 0; i < NUM_CH; i++) live[i] <= '0;
        win_sat    <= '0;
        sat_flags  <= '0;
        timer      <= '0;
        window_idx <= '0;
      end
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.window_done = window_done;
  assign bus.window_idx  = window_idx;
  assign bus.sat_flags   = sat_flags;
  assign bus.busy        = (state != IDLE);
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed bench for spike_window_counter (CNT_W=4 so saturation is reachable);
// expected values are hand-computed per step.
module tb_spike_window_counter;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 24;
  localparam int SEL_W  = 6;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  spike_window_counter_if #(.NUM_CH(NUM_CH), .WIN_W(WIN_W), .SEL_W(SEL_W)) bus ();

  spike_window_counter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SEL_W(SEL_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one edge, then settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.clear      = 1'b0;
    bus.window_len = '0;
    bus.spike_in   = '0;
    bus.rd_sel     = '0;
    repeat (3) tick();

    // reset state
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_done", 32'(bus.window_done), 32'h0);
    check("rst_idx", 32'(bus.window_idx), 32'h0);
    check("rst_sat", 32'(bus.sat_flags), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_state", 32'(bus.state_dbg), 32'h0);
    reset = 1'b0;
    tick();

    // window of 10: ch0 always, ch1 every other cycle; entry-edge spike ignored
    bus.run        = 1'b1;
    bus.window_len = 24'd10;
    bus.spike_in   = 16'h0001;
    tick();
    check("t1_busy", 32'(bus.busy), 32'h1);
    check("t1_state", 32'(bus.state_dbg), 32'h1);
    for (int k = 0; k < 10; k++) begin
      bus.spike_in = (k % 2 == 0) ? 16'h0003 : 16'h0001;
      tick();
      check("t1_done", 32'(bus.window_done), (k == 9) ? 32'h1 : 32'h0);
    end
    check("t1_idx", 32'(bus.window_idx), 32'h1);

    // ch2 for 30 cycles: three back-to-back windows, reads of window 1 on the way
    for (int n = 1; n <= 30; n++) begin
      bus.spike_in = 16'h0004;
      bus.rd_sel   = (n == 1) ? 6'd0 : (n == 2) ? 6'd1 : (n == 3) ? 6'd63 : 6'd2;
      tick();
      check("t2_done", 32'(bus.window_done), (n % 10 == 0) ? 32'h1 : 32'h0);
      if (n == 1)  check("t1_snap0", bus.rd_data, 32'h0000_000A);
      if (n == 2)  check("t1_snap1", bus.rd_data, 32'h0000_0005);
      if (n == 3)  check("t1_idx_rd", bus.rd_data, 32'h0000_0001);
      if (n == 11) check("t2_snap2_w2", bus.rd_data, 32'h0000_000A);
      if (n == 21) check("t2_snap2_w3", bus.rd_data, 32'h0000_000A);
    end
    check("t2_idx", 32'(bus.window_idx), 32'h4);
    bus.spike_in = '0;
    tick();
    check("t2_snap2_w4", bus.rd_data, 32'h0000_000A);

    // window_len change mid-window takes effect only at the boundary
    bus.window_len = 24'd20;
    for (int n = 32; n <= 40; n++) begin
      tick();
      check("t3_len_hold", 32'(bus.window_done), (n == 40) ? 32'h1 : 32'h0);
    end

    // 20-cycle window with ch3 constant saturates a 4-bit counter at 15
    for (int m = 1; m <= 20; m++) begin
      bus.spike_in = 16'h0008;
      if (m == 1) bus.window_len = 24'd10;
      tick();
      if (m == 15) check("t3_sat_pre", 32'(bus.sat_flags), 32'h0);
      if (m == 16) check("t3_sat_set", 32'(bus.sat_flags), 32'h0008);
      check("t3_done", 32'(bus.window_done), (m == 20) ? 32'h1 : 32'h0);
    end
    check("t3_idx", 32'(bus.window_idx), 32'h6);
    bus.spike_in = '0;
    bus.rd_sel   = 6'd3;
    tick();
    check("t3_snap3", bus.rd_data, 32'h8000_000F);
    for (int r = 2; r <= 10; r++) begin
      tick();
      check("t3_quiet_done", 32'(bus.window_done), (r == 10) ? 32'h1 : 32'h0);
    end

    // sticky flag survives a non-saturating window; run drop drains the window
    bus.spike_in = 16'h0001;
    tick();
    check("t3_snap3_clean", bus.rd_data, 32'h0);
    check("t3_sat_sticky", 32'(bus.sat_flags), 32'h0008);
    repeat (3) tick();
    bus.run = 1'b0;
    tick();
    check("t4_drain_state", 32'(bus.state_dbg), 32'h2);
    check("t4_drain_busy", 32'(bus.busy), 32'h1);
    repeat (4) tick();
    check("t4_pre_done", 32'(bus.window_done), 32'h0);
    tick();
    check("t4_done", 32'(bus.window_done), 32'h1);
    check("t4_busy", 32'(bus.busy), 32'h0);
    check("t4_state", 32'(bus.state_dbg), 32'h0);
    check("t4_idx", 32'(bus.window_idx), 32'h8);
    bus.rd_sel = 6'd0;
    tick();
    check("t4_snap0", bus.rd_data, 32'h0000_000A);
    for (int q = 0; q < 5; q++) begin
      tick();
      check("t4_idle_done", 32'(bus.window_done), 32'h0);
      check("t4_idle_busy", 32'(bus.busy), 32'h0);
    end

    // clear on the terminal cycle suppresses the boundary
    bus.run        = 1'b1;
    bus.window_len = 24'd5;
    tick();
    for (int j = 1; j <= 5; j++) begin
      if (j == 5) bus.clear = 1'b1;
      tick();
    end
    bus.clear = 1'b0;
    check("t5_done", 32'(bus.window_done), 32'h0);
    check("t5_idx", 32'(bus.window_idx), 32'h0);
    check("t5_sat", 32'(bus.sat_flags), 32'h0);
    check("t5_busy", 32'(bus.busy), 32'h1);
    for (int j = 1; j <= 5; j++) begin
      if (j == 5) bus.window_len = 24'd0;
      tick();
      if (j == 1) check("t5_snap_kept", bus.rd_data, 32'h0000_000A);
      check("t5_next_done", 32'(bus.window_done), (j == 5) ? 32'h1 : 32'h0);
    end
    check("t5_next_idx", 32'(bus.window_idx), 32'h1);

    // window_len 0 behaves as 1; read-map corners
    bus.spike_in = '0;
    tick();
    check("t6_snap0_after_clear", bus.rd_data, 32'h0000_0005);
    check("t6_done_a", 32'(bus.window_done), 32'h1);
    check("t6_idx_a", 32'(bus.window_idx), 32'h2);
    bus.rd_sel = 6'd63;
    tick();
    check("t6_rd_idx", bus.rd_data, 32'h0000_0002);
    check("t6_done_b", 32'(bus.window_done), 32'h1);
    check("t6_idx_b", 32'(bus.window_idx), 32'h3);
    bus.rd_sel = 6'(NUM_CH);
    tick();
    check("t6_rd_unmapped", bus.rd_data, 32'h0);
    check("t6_done_c", 32'(bus.window_done), 32'h1);

    // reset in the middle of a 10-cycle window
    bus.window_len = 24'd10;
    bus.spike_in   = 16'h0001;
    bus.rd_sel     = 6'd63;
    tick();
    check("t6_idx_d", 32'(bus.window_idx), 32'h5);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t6_rst_rd_data", bus.rd_data, 32'h0);
    check("t6_rst_done", 32'(bus.window_done), 32'h0);
    check("t6_rst_idx", 32'(bus.window_idx), 32'h0);
    check("t6_rst_busy", 32'(bus.busy), 32'h0);
    check("t6_rst_state", 32'(bus.state_dbg), 32'h0);
    reset      = 1'b0;
    bus.run    = 1'b0;
    bus.rd_sel = 6'd0;
    tick();
    check("t6_rst_snap0", bus.rd_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
